// File: rtl/axi_burst_master.sv
// AXI4 burst initiator: one legal INCR/WRAP/FIXED burst per command, write or read.
module axi_burst_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    // command interface
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [2:0]                cmd_size,
    input  logic [1:0]                cmd_burst,
    // write-beat source
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb,
    // read-beat sink
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic [1:0]                rd_resp,
    output logic                      rd_last,
    // completion
    output logic                      done,
    output logic [1:0]                done_resp,
    output logic                      proto_err,
    // AXI write address
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic [7:0]                AWLEN,
    output logic [2:0]                AWSIZE,
    output logic [1:0]                AWBURST,
    // AXI write data
    output logic                      WVALID,
    input  logic                      WREADY,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      WLAST,
    // AXI write response
    input  logic                      BVALID,
    output logic                      BREADY,
    input  logic [1:0]                BRESP,
    // AXI read address
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    // AXI read data
    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RLAST
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned MAX_SIZE = $clog2(STRB_W);
    localparam int unsigned EXT_W    = ADDR_WIDTH + 12;

    typedef enum logic [2:0] {
        IDLE, CHECK, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA, DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic                    write_q, write_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    wvalid_q, wvalid_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    wlast_q, wlast_d;
    logic [8:0]              cnt_q, cnt_d;
    logic [1:0]              acc_q, acc_d;
    logic                    perr_q, perr_d;
    logic                    done_q, done_d;
    logic [1:0]              done_resp_q, done_resp_d;
    logic                    proto_err_q, proto_err_d;

    logic                    illegal;
    logic [EXT_W-1:0]        addr_ext, nbytes, last_byte;
    logic [ADDR_WIDTH-1:0]   align_mask;
    logic                    wr_hs;
    logic [1:0]              beat_resp, acc_nxt;
    logic                    perr_nxt;

    // Burst legality of the captured descriptor, evaluated during CHECK.
    always_comb begin
        illegal    = 1'b0;
        addr_ext   = EXT_W'(addr_q);
        nbytes     = (EXT_W'(len_q) + EXT_W'(1)) << size_q;
        last_byte  = addr_ext + nbytes - EXT_W'(1);
        align_mask = (ADDR_WIDTH'(1) << size_q) - ADDR_WIDTH'(1);
        if (burst_q == 2'b11) illegal = 1'b1;
        if (size_q > 3'(MAX_SIZE)) illegal = 1'b1;
        if (burst_q == 2'b10) begin
            if (!(len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15))
                illegal = 1'b1;
            if ((addr_q & align_mask) != '0) illegal = 1'b1;
        end
        if (burst_q == 2'b01 && (last_byte >> 12) != (addr_ext >> 12)) illegal = 1'b1;
        if (burst_q == 2'b00 && len_q > 8'd15) illegal = 1'b1;
    end

    assign wr_ready = (state_q == W_DATA) && (!wvalid_q || WREADY) && (cnt_q <= 9'(len_q));
    assign wr_hs    = wr_valid && wr_ready;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        write_d     = write_q;
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wlast_d     = wlast_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        perr_d      = perr_q;
        done_resp_d = done_resp_q;
        proto_err_d = proto_err_q;
        beat_resp   = 2'b00;
        acc_nxt     = acc_q;
        perr_nxt    = perr_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    size_d  = cmd_size;
                    burst_d = cmd_burst;
                    write_d = cmd_write;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                cnt_d  = '0;
                acc_d  = 2'b00;
                perr_d = 1'b0;
                if (illegal) begin
                    done_resp_d = 2'b10;
                    proto_err_d = 1'b0;
                    state_d     = DONE;
                end else if (write_q) begin
                    state_d = W_ADDR;
                end else begin
                    state_d = R_ADDR;
                end
            end
            W_ADDR: begin
                if (AWREADY) state_d = W_DATA;
            end
            W_DATA: begin
                if (wr_hs) begin
                    wvalid_d = 1'b1;
                    wdata_d  = wr_data;
                    wstrb_d  = wr_strb;
                    wlast_d  = (cnt_q == 9'(len_q));
                    cnt_d    = cnt_q + 9'd1;
                end else if (wvalid_q && WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (wvalid_q && WREADY && wlast_q) state_d = W_RESP;
            end
            W_RESP: begin
                if (BVALID) begin
                    done_resp_d = BRESP;
                    proto_err_d = 1'b0;
                    state_d     = DONE;
                end
            end
            R_ADDR: begin
                if (ARREADY) state_d = R_DATA;
            end
            R_DATA: begin
                if (RVALID && rd_ready) begin
                    beat_resp = (RRESP == 2'b01) ? 2'b00 : RRESP;
                    acc_nxt   = (beat_resp > acc_q) ? beat_resp : acc_q;
                    perr_nxt  = perr_q
                              | (RLAST && (cnt_q < 9'(len_q)))
                              | (!RLAST && (cnt_q == 9'(len_q)));
                    cnt_d     = cnt_q + 9'd1;
                    acc_d     = acc_nxt;
                    perr_d    = perr_nxt;
                    if (RLAST) begin
                        done_resp_d = (perr_nxt && acc_nxt < 2'b10) ? 2'b10 : acc_nxt;
                        proto_err_d = perr_nxt;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cmd_ready_d = (state_d == IDLE);
        awvalid_d   = (state_d == W_ADDR);
        arvalid_d   = (state_d == R_ADDR);
        bready_d    = (state_d == W_RESP);
        done_d      = (state_d == DONE);
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            write_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wlast_q     <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= 2'b00;
            perr_q      <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= 2'b00;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            write_q     <= write_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wlast_q     <= wlast_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            perr_q      <= perr_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign done_resp = done_resp_q;
    assign proto_err = proto_err_q;

    assign AWVALID = awvalid_q;
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = size_q;
    assign AWBURST = burst_q;

    assign WVALID  = wvalid_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = wlast_q;
    assign BREADY  = bready_q;

    assign ARVALID = arvalid_q;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = size_q;
    assign ARBURST = burst_q;

    // Read data path is a straight pass-through while the read burst is open.
    assign rd_valid = (state_q == R_DATA) && RVALID;
    assign RREADY   = (state_q == R_DATA) && rd_ready;
    assign rd_data  = RDATA;
    assign rd_resp  = RRESP;
    assign rd_last  = RLAST;

endmodule
